// File: rtl/f1_rd_if.sv
// ---------------------------------------------------------------------------
// f1_rd_if
// Handshake/bus bundle between the f1 read sequencer and its controller/MAC.
//   start      controller -> sequencer   1-cycle run request (IDLE only)
//   hold       controller -> sequencer   freeze the address walk
//   abort      controller -> sequencer   only when F1_RD_ABORT_EN is defined
//   f1_raddr   sequencer  -> f1_ram      pixel read address
//   tap_valid/tap_first/tap_last/out_x/out_y
//              sequencer  -> MAC         tap qualifiers aligned to f1_rdata
//   busy, done sequencer  -> controller  run status
// Optional feature macro: F1_RD_ABORT_EN
// ---------------------------------------------------------------------------
interface f1_rd_if #(
    parameter int AW = 10,
    parameter int CW = 5
);
    logic          start;
    logic          hold;
`ifdef F1_RD_ABORT_EN
    logic          abort;
`endif
    logic [AW-1:0] f1_raddr;
    logic          tap_valid;
    logic          tap_first;
    logic          tap_last;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          busy;
    logic          done;

`ifdef F1_RD_ABORT_EN
    modport master (
        output start, hold, abort,
        input  f1_raddr, tap_valid, tap_first, tap_last, out_x, out_y, busy, done
    );
    modport slave (
        input  start, hold, abort,
        output f1_raddr, tap_valid, tap_first, tap_last, out_x, out_y, busy, done
    );
`else
    modport master (
        output start, hold,
        input  f1_raddr, tap_valid, tap_first, tap_last, out_x, out_y, busy, done
    );
    modport slave (
        input  start, hold,
        output f1_raddr, tap_valid, tap_first, tap_last, out_x, out_y, busy, done
    );
`endif
endinterface

// File: rtl/f1_rd_ctrl.sv
// ---------------------------------------------------------------------------
// f1_rd_ctrl
// Read-address sequencer for the conv-layer-1 feature RAM (2-cycle read
// latency). Walks every KxK window of the IMG_W x IMG_H map, windows and taps
// both row-major, and delivers tap qualifiers aligned with f1_rdata.
// Ports:
//   clk    in   clock, also clocks the f1_ram read port
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of f1_rd_if (start/hold/abort in; address, tap
//               qualifiers, out_x/out_y, busy, done out)
// Optional feature macro: F1_RD_ABORT_EN (adds abort of a run in progress)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start, address 0, counters cleared
// S_RUN   | issuing one read per non-held cycle
// S_FLUSH | last address issued, draining the 2-stage tap pipe
// ---------------------------------------------------------------------------
module f1_rd_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5,
    parameter int AW    = 10,
    parameter int CW    = 5
) (
    input logic    clk,
    input logic    rst_n,
    f1_rd_if.slave bus
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int KCW   = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [KCW-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [CW-1:0]  ox_q, ox_d, oy_q, oy_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  row_c, col_c;

    logic           p1_valid_q, p1_first_q, p1_last_q;
    logic [CW-1:0]  p1_x_q, p1_y_q;
    logic           p2_valid_q, p2_first_q, p2_last_q;
    logic [CW-1:0]  p2_x_q, p2_y_q;

    logic           issue, take, win_first, win_last, abort_c, done_c;

`ifdef F1_RD_ABORT_EN
    assign abort_c = bus.abort && (state_q != S_IDLE);
`else
    assign abort_c = 1'b0;
`endif

    assign issue     = (state_q == S_RUN) && !bus.hold;
    assign take      = issue && !abort_c;
    assign win_first = (kx_q == '0) && (ky_q == '0);
    assign win_last  = (kx_q == KCW'(K - 1)) && (ky_q == KCW'(K - 1));

    always_comb begin
        state_d = state_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                kx_d = '0;
                ky_d = '0;
                ox_d = '0;
                oy_d = '0;
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    if (kx_q != KCW'(K - 1)) begin
                        kx_d = kx_q + 1'b1;
                    end else begin
                        kx_d = '0;
                        if (ky_q != KCW'(K - 1)) begin
                            ky_d = ky_q + 1'b1;
                        end else begin
                            ky_d = '0;
                            if (ox_q != CW'(OUT_W - 1)) begin
                                ox_d = ox_q + 1'b1;
                            end else begin
                                ox_d = '0;
                                if (oy_q != CW'(OUT_H - 1)) begin
                                    oy_d = oy_q + 1'b1;
                                end else begin
                                    oy_d    = '0;
                                    state_d = S_FLUSH;
                                end
                            end
                        end
                    end
                end
            end
            S_FLUSH: begin
                // Nothing is issued in FLUSH, so stage 1 is empty exactly when
                // the final tap sits in stage 2 (also correct for K=1 where
                // every tap is a window's last).
                if (p2_valid_q && p2_last_q && !p1_valid_q) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_c) begin
            state_d = S_IDLE;
            kx_d    = '0;
            ky_d    = '0;
            ox_d    = '0;
            oy_d    = '0;
            done_c  = 1'b0;
        end

        // Counters are zero outside RUN, so the address falls back to 0 there.
        row_c  = AW'(oy_d) + AW'(ky_d);
        col_c  = AW'(ox_d) + AW'(kx_d);
        addr_d = row_c * AW'(IMG_W) + col_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kx_q    <= '0;
            ky_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            addr_q  <= addr_d;
        end
    end

    // Alignment pipe: shifts every cycle; a held or idle cycle inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_x_q     <= '0;
            p1_y_q     <= '0;
            p2_valid_q <= 1'b0;
            p2_first_q <= 1'b0;
            p2_last_q  <= 1'b0;
            p2_x_q     <= '0;
            p2_y_q     <= '0;
        end else begin
            p1_valid_q <= take;
            p1_first_q <= take && win_first;
            p1_last_q  <= take && win_last;
            p1_x_q     <= ox_q;
            p1_y_q     <= oy_q;
            p2_valid_q <= p1_valid_q && !abort_c;
            p2_first_q <= p1_first_q && !abort_c;
            p2_last_q  <= p1_last_q && !abort_c;
            p2_x_q     <= p1_x_q;
            p2_y_q     <= p1_y_q;
        end
    end

    assign bus.f1_raddr  = addr_q;
    assign bus.tap_valid = p2_valid_q;
    assign bus.tap_first = p2_first_q;
    assign bus.tap_last  = p2_last_q;
    assign bus.out_x     = p2_x_q;
    assign bus.out_y     = p2_y_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_c;
endmodule
